// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
//   XLEN / WSTRB_W : data/address width and byte-strobe width
//   mem_state_t    : responder FSM state encoding
//   addr_in_range  : window check done in XLEN+1 bits, so that base+span cannot wrap
package mem_pkg;

  localparam int XLEN    = 32;
  localparam int WSTRB_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_t;

  // True when base <= addr < base + span_bytes. All operands are widened by
  // one bit, so a window that ends exactly at 2^32 is still handled correctly.
  function automatic logic addr_in_range(
    input logic [XLEN-1:0] addr,
    input logic [XLEN-1:0] base,
    input logic [XLEN:0]   span_bytes
  );
    logic [XLEN:0] a_w;
    logic [XLEN:0] lo_w;
    logic [XLEN:0] hi_w;
    a_w  = {1'b0, addr};
    lo_w = {1'b0, base};
    hi_w = lo_w + span_bytes;
    return (a_w >= lo_w) && (a_w < hi_w);
  endfunction

endpackage

// File: rtl/mem_array_1rw.sv
// Word array with one shared port.
//   clk     : write clock
//   we_i    : write enable. Only the lanes enabled by wstrb_i are written.
//   idx_i   : word index, used for both read and write
//   wstrb_i : byte-lane enables. Bit i covers wdata_i[8i+7:8i].
//   wdata_i : write data
//   rdata_o : combinational read of the word at idx_i
// Contents are never reset.
module mem_array_1rw
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [WSTRB_W-1:0] wstrb_i,
  input  logic [XLEN-1:0]    wdata_i,
  output logic [XLEN-1:0]    rdata_o
);

  // Each byte lane is stored as its own array, so a masked write is simply a
  // write enable on each lane.
  genvar gi;
  for (gi = 0; gi < WSTRB_W; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];

    always_ff @(posedge clk) begin
      if (we_i && wstrb_i[gi]) begin
        lane_q[idx_i] <= wdata_i[8*gi +: 8];
      end
    end

    assign rdata_o[8*gi +: 8] = lane_q[idx_i];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the data access port.
//   clk, reset : rising-edge clock; asynchronous active-high reset
//   addr_bus   : byte address from the initiator
//   mem_oe     : read request
//   mem_we     : write request
//   mem_wstrb  : byte-lane write enables
//   mem_wdata  : write data
//   data_bus   : read data. It is non-zero only during a successful read response.
//   mem_ready  : one-cycle response pulse, issued WAIT_STATES+1 cycles after acceptance
//   mem_err    : qualifies mem_ready. When high, the request was rejected and had no memory effect.
// The responder accepts a request only in IDLE and then works only from the
// captured copy. Input changes after acceptance therefore have no effect.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 1024,
  parameter int              WAIT_STATES = 2,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    addr_bus,
  input  logic               mem_oe,
  input  logic               mem_we,
  input  logic [WSTRB_W-1:0] mem_wstrb,
  input  logic [XLEN-1:0]    mem_wdata,
  output logic [XLEN-1:0]    data_bus,
  output logic               mem_ready,
  output logic               mem_err
);

  localparam int              IDX_W      = $clog2(DEPTH_WORDS);
  localparam int              CNT_W      = $clog2(16);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [XLEN:0]   SPAN_BYTES = {1'b0, XLEN'(DEPTH_WORDS)} << 2;

  mem_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
  logic               read_q, read_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0]   req_idx;
  logic               req_err;
  logic               array_we;
  logic [XLEN-1:0]    array_rdata;

  // Decode the live bus. The result is kept only when the request is
  // accepted in IDLE. When both strobes are high, the request is flagged as
  // an error, so a non-error request with read_q low is a genuine write.
  assign req_idx = IDX_W'((addr_bus - BASE_ADDR) >> 2);
  assign req_err = (addr_bus[1:0] != 2'b00)
                 | ~addr_in_range(addr_bus, BASE_ADDR, SPAN_BYTES)
                 | (mem_oe & mem_we);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      read_q  <= read_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    read_d    = read_q;
    err_d     = err_q;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    data_bus  = '0;
    array_we  = 1'b0;

    unique case (state_q)
      MEM_IDLE: begin
        if (mem_oe | mem_we) begin
          idx_d   = req_idx;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          read_d  = mem_oe;
          err_d   = req_err;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_STATES > 0) ? MEM_WAIT : MEM_RESP;
        end
      end
      MEM_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = MEM_RESP;
        end
      end
      MEM_RESP: begin
        mem_ready = 1'b1;
        mem_err   = err_q;
        if (read_q && !err_q) begin
          data_bus = array_rdata;
        end
        // The write commits on the edge that leaves RESP. An asynchronous
        // reset during RESP drops state_q first, which cancels the write.
        array_we = ~read_q & ~err_q;
        state_d  = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  mem_array_1rw #(
    .DEPTH(DEPTH_WORDS),
    .IDX_W(IDX_W)
  ) u_array (
    .clk    (clk),
    .we_i   (array_we),
    .idx_i  (idx_q),
    .wstrb_i(wstrb_q),
    .wdata_i(wdata_q),
    .rdata_o(array_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int          DEPTH = 1024;
  localparam int          WS0   = 2;
  localparam logic [31:0] BASE0 = 32'h0;
  localparam int          WS1   = 0;
  localparam logic [31:0] BASE1 = 32'h1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  wstrb_s [2];
  logic        oe_s    [2];
  logic        we_s    [2];

  logic [31:0] data0, data1;
  logic        rdy0, rdy1, err0, err1;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0), .BASE_ADDR(BASE0)) u_dut_a (
    .clk(clk), .reset(reset), .addr_bus(addr_s[0]), .mem_oe(oe_s[0]), .mem_we(we_s[0]),
    .mem_wstrb(wstrb_s[0]), .mem_wdata(wdata_s[0]),
    .data_bus(data0), .mem_ready(rdy0), .mem_err(err0));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1), .BASE_ADDR(BASE1)) u_dut_b (
    .clk(clk), .reset(reset), .addr_bus(addr_s[1]), .mem_oe(oe_s[1]), .mem_we(we_s[1]),
    .mem_wstrb(wstrb_s[1]), .mem_wdata(wdata_s[1]),
    .data_bus(data1), .mem_ready(rdy1), .mem_err(err1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction
  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction
  function automatic logic [31:0] dout(input int d);
    return (d == 0) ? data0 : data1;
  endfunction
  function automatic logic rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic erf(input int d);
    return (d == 0) ? err0 : err1;
  endfunction

  // ---------------- behavioural model ----------------
  // Each responder is modelled as busy from acceptance until the edge after
  // its response cycle. The response cycle is acceptance + WAIT_STATES, counted
  // in posedges.
  longint      cyc = 0;
  bit          m_busy    [2];
  longint      m_resp_at [2];
  bit          m_err     [2];
  bit          m_read    [2];
  int          m_idx     [2];
  logic [31:0] m_wdata   [2];
  logic [3:0]  m_wstrb   [2];
  logic [31:0] m_mem     [2][DEPTH];
  bit          m_known   [2][DEPTH];

  function automatic bit decode_err(input int d, input logic [31:0] a, input logic oe, input logic we);
    longint aa, lo, hi;
    aa = longint'(a);
    lo = longint'(base_of(d));
    hi = lo + 4 * DEPTH;
    return (a[1:0] != 2'b00) || (aa < lo) || (aa >= hi) || (oe && we);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) m_busy[d] = 1'b0;
    end else begin
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (m_busy[d]) begin
          if (cyc == m_resp_at[d] + 1) begin
            if (!m_err[d] && !m_read[d]) begin
              for (int b = 0; b < 4; b++) begin
                if (m_wstrb[d][b]) m_mem[d][m_idx[d]][8*b +: 8] = m_wdata[d][8*b +: 8];
              end
              if (m_wstrb[d] == 4'hF) m_known[d][m_idx[d]] = 1'b1;
            end
            m_busy[d] = 1'b0;
          end
        end else if (oe_s[d] || we_s[d]) begin
          m_busy[d]    = 1'b1;
          m_resp_at[d] = cyc + ws_of(d);
          m_err[d]     = decode_err(d, addr_s[d], oe_s[d], we_s[d]);
          m_read[d]    = oe_s[d];
          m_idx[d]     = int'((addr_s[d] - base_of(d)) >> 2) % DEPTH;
          m_wdata[d]   = wdata_s[d];
          m_wstrb[d]   = wstrb_s[d];
        end
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  bit          c_resp;
  logic [31:0] c_exp;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      c_resp = !reset && m_busy[d] && (cyc == m_resp_at[d]);
      check($sformatf("ready[%0d]", d), 32'(rdy(d)), 32'(c_resp));
      if (c_resp) begin
        check($sformatf("err[%0d]", d), 32'(erf(d)), 32'(m_err[d]));
        if (m_err[d]) begin
          check($sformatf("errdata[%0d]", d), dout(d), 32'h0);
        end else if (m_read[d] && m_known[d][m_idx[d]]) begin
          c_exp = m_mem[d][m_idx[d]];
          check($sformatf("rdata[%0d]", d), dout(d), c_exp);
        end
      end else begin
        check($sformatf("idle_err[%0d]", d), 32'(erf(d)), 32'h0);
        check($sformatf("idle_data[%0d]", d), dout(d), 32'h0);
      end
    end
  end

  // ---------------- transaction driver ----------------
  // The task starts with one idle cycle, so the request always meets IDLE.
  // With scramble set, the inputs are changed at random after acceptance.
  task automatic txn(input int d, input logic [31:0] a, input logic oe, input logic we,
                     input logic [3:0] st, input logic [31:0] wd, input bit scramble,
                     output logic [31:0] rd, output logic er, output int lat);
    bit done;
    @(negedge clk);
    addr_s[d] = a; oe_s[d] = oe; we_s[d] = we; wstrb_s[d] = st; wdata_s[d] = wd;
    lat = 0; rd = '0; er = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (rdy(d)) begin
        rd = dout(d); er = erf(d); done = 1'b1;
      end else if (scramble) begin
        addr_s[d]  = $urandom;
        wdata_s[d] = $urandom;
        wstrb_s[d] = 4'($urandom);
        oe_s[d]    = 1'($urandom);
        we_s[d]    = 1'($urandom);
      end
    end
    oe_s[d] = 1'b0; we_s[d] = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL timeout[%0d]: no mem_ready within 40 cycles (addr %h)", d, a);
    end
    $display("txn dut%0d addr=%h oe=%0b we=%0b strb=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             d, a, oe, we, st, wd, rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          nready, last_at, gap_bad;
  int          cat, d;
  logic [31:0] a;
  logic        o, w;

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr_s[i] = '0; wdata_s[i] = '0; wstrb_s[i] = '0; oe_s[i] = 1'b0; we_s[i] = 1'b0;
    end
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready0", 32'(rdy0), 32'h0);
    check("reset_err0", 32'(err0), 32'h0);
    check("reset_data0", data0, 32'h0);
    check("reset_ready1", 32'(rdy1), 32'h0);
    reset = 1'b0;

    // Basic write/read on dut0: WAIT_STATES=2, so each response has latency 3.
    txn(0, 32'h10, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, rd, er, lat);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_err", 32'(er), 32'h0);
    txn(0, 32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_data", rd, 32'hDEADBEEF);

    // Byte strobes.
    txn(0, 32'h20, 1'b0, 1'b1, 4'hF, 32'h11223344, 1'b0, rd, er, lat);
    txn(0, 32'h20, 1'b0, 1'b1, 4'b0101, 32'hAABBCCDD, 1'b0, rd, er, lat);
    txn(0, 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("strobe_data", rd, 32'h11BB33DD);
    txn(0, 32'h20, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, rd, er, lat);
    check("zero_strobe_err", 32'(er), 32'h0);
    txn(0, 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("zero_strobe_data", rd, 32'h11BB33DD);

    // Error cases.
    txn(0, 32'h13, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("misalign_err", 32'(er), 32'h1);
    check("misalign_data", rd, 32'h0);
    txn(0, 32'(4*DEPTH), 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("range_err", 32'(er), 32'h1);
    txn(0, 32'(4*DEPTH-4), 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("last_word_err", 32'(er), 32'h0);
    txn(0, 32'h10, 1'b1, 1'b1, 4'hF, 32'h0, 1'b0, rd, er, lat);
    check("oe_we_err", 32'(er), 32'h1);
    txn(0, 32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("oe_we_nowrite", rd, 32'hDEADBEEF);

    // dut1: non-zero base and zero wait states.
    txn(1, 32'h0FFC, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("below_base_err", 32'(er), 32'h1);
    txn(1, 32'h2000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("above_span_err", 32'(er), 32'h1);
    txn(1, 32'h1000, 1'b0, 1'b1, 4'hF, 32'h0BADF00D, 1'b0, rd, er, lat);
    check("ws0_latency", 32'(lat), 32'd1);
    txn(1, 32'h1000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("base_rd_data", rd, 32'h0BADF00D);

    // Back-to-back reads with the request held continuously.
    @(negedge clk);
    addr_s[1] = 32'h1000; oe_s[1] = 1'b1; we_s[1] = 1'b0;
    nready = 0; last_at = -1; gap_bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rdy1) begin
        if (last_at >= 0 && i - last_at != 2) gap_bad++;
        last_at = i; nready++;
        $display("b2b read cycle %0d data=%h", i, data1);
      end
    end
    oe_s[1] = 1'b0;
    check("b2b_count", 32'(nready), 32'd5);
    check("b2b_gap", 32'(gap_bad), 32'd0);

    // A reset during WAIT aborts the write.
    txn(0, 32'h30, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0, rd, er, lat);
    @(negedge clk);
    addr_s[0] = 32'h30; we_s[0] = 1'b1; wstrb_s[0] = 4'hF; wdata_s[0] = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(rdy0), 32'h0);
    check("rst_data", data0, 32'h0);
    we_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nready = 0;
    repeat (5) begin
      @(negedge clk);
      if (rdy0) nready++;
    end
    check("rst_no_resp", 32'(nready), 32'd0);
    txn(0, 32'h30, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    check("rst_no_write", rd, 32'h0);

    // Randomized traffic. The per-cycle compare process checks it against the model.
    for (int n = 0; n < 200; n++) begin
      d   = int'($urandom_range(0, 1));
      cat = int'($urandom_range(0, 11));
      o   = 1'($urandom);
      w   = ~o;
      case (cat)
        7:  a = base_of(d) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        8:  a = base_of(d) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        9:  a = (d == 1) ? base_of(d) - 32'(4 * $urandom_range(1, 4)) : 32'(4 * DEPTH + 64);
        10: begin a = base_of(d) + 32'(4 * $urandom_range(0, 15)); o = 1'b1; w = 1'b1; end
        11: a = base_of(d) + 32'(4 * (DEPTH - 1));
        default: a = base_of(d) + 32'(4 * $urandom_range(0, 15));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn(d, a, o, w, 4'($urandom), $urandom, 1'($urandom), rd, er, lat);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
